// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter driving a shared 1-bit channel mux, with registered grant/select/valid.
// Optional burst limiting is compiled in with `define BURST_LIMIT_EN (MAX_BURST sets the per-grant cycle cap).
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no grant active; arbitrates on any request
// ST_GRANT| one requester owns the channel until its req drops (or burst cap)
module rr_mux_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [3:0] grant,
  output logic [1:0] s,
  output logic       valid,
  output logic       y
);

  if (MAX_BURST < 2 || MAX_BURST > 16) begin : g_bad_max_burst
    $error("rr_mux_arbiter: MAX_BURST must be in 2..16");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_grant;
  logic [3:0]  w_grant_nxt;
  logic [1:0]  r_s;
  logic [1:0]  w_s_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  w_ptr_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic [3:0]  w_arb_req;
  logic        w_arb_any;
  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic        w_take_win;
  logic        w_burst_end;

`ifdef BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_burst_end = (r_cnt == CNT_W'(MAX_BURST - 1));
`else
  assign w_burst_end = 1'b0;
`endif

  // The current owner is masked so a forced release can never re-pick it.
  assign w_arb_req = (r_state == ST_GRANT) ? (req & ~r_grant) : req;

  always_comb begin
    w_win     = r_ptr;
    w_arb_any = 1'b0;
    w_idx     = r_ptr;
    // Scan farthest-first so the closest set bit to ptr is the one left standing.
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (w_arb_req[w_idx]) begin
        w_win     = w_idx;
        w_arb_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_s_nxt     = r_s;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    w_take_win  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_arb_any) w_take_win = 1'b1;
      end
      ST_GRANT: begin
        if (!req[r_s]) begin
          if (w_arb_any) begin
            w_take_win = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 4'b0000;
            w_valid_nxt = 1'b0;
          end
        end else if (w_burst_end && w_arb_any) begin
          w_take_win = 1'b1;
        end
      end
    endcase

    if (w_take_win) begin
      w_state_nxt = ST_GRANT;
      w_grant_nxt = 4'b0001 << w_win;
      w_s_nxt     = w_win;
      w_valid_nxt = 1'b1;
      w_ptr_nxt   = w_win + 2'd1;
    end
  end

`ifdef BURST_LIMIT_EN
  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(1);
    if (w_take_win || w_state_nxt != ST_GRANT || w_burst_end) w_cnt_nxt = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= 4'b0000;
      r_s     <= 2'b00;
      r_valid <= 1'b0;
      r_ptr   <= 2'b00;
`ifdef BURST_LIMIT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_s     <= w_s_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
`ifdef BURST_LIMIT_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  assign grant = r_grant;
  assign s     = r_s;
  assign valid = r_valid;
  assign y     = r_valid & i[r_s];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter; burst-limit scenarios follow BURST_LIMIT_EN.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] i;
  logic [3:0] grant;
  logic [1:0] s;
  logic       valid;
  logic       y;

  int checks;
  int errors;

  rr_mux_arbiter #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .i     (i),
    .grant (grant),
    .s     (s),
    .valid (valid),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    i   = 4'b1111;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp %b", grant, 4'b0000); end
    checks++;
    if (s !== 2'b00) begin errors++; $display("FAIL reset_s got %b exp %b", s, 2'b00); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp %b", valid, 1'b0); end
    checks++;
    if (y !== 1'b0) begin errors++; $display("FAIL reset_y got %b exp %b", y, 1'b0); end
    rst = 1'b0;
    req = 4'b0000;
    i   = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    i   = 4'b0001;
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL single_pre_edge_valid got %b exp %b", valid, 1'b0); end
    tick();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp %b", grant, 4'b0001); end
    checks++;
    if (s !== 2'b00) begin errors++; $display("FAIL single_s got %b exp %b", s, 2'b00); end
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp %b", valid, 1'b1); end
    checks++;
    if (y !== 1'b1) begin errors++; $display("FAIL single_y got %b exp %b", y, 1'b1); end
    req = 4'b0000;
    tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL single_drop_valid got %b exp %b", valid, 1'b0); end
    checks++;
    if (y !== 1'b0) begin errors++; $display("FAIL single_drop_y got %b exp %b", y, 1'b0); end
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL single_drop_grant got %b exp %b", grant, 4'b0000); end
    i = 4'b0000;
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      tick();
      checks++;
      if (grant !== exp_g || valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation_first_cycle idx %0d got grant %b valid %b exp grant %b valid 1", g, grant, valid, exp_g);
      end
      req = 4'b1111;
      tick();
      checks++;
      if (grant !== exp_g || valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation_hold_cycle idx %0d got grant %b valid %b exp grant %b valid 1", g, grant, valid, exp_g);
      end
      req = 4'b1111 & ~exp_g;
    end
    req = 4'b0000;
    tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL rotation_idle_valid got %b exp %b", valid, 1'b0); end
  endtask

  task automatic test_comb_y();
    do_reset();
    req = 4'b0100;
    i   = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0100 || s !== 2'b10) begin
      errors++;
      $display("FAIL comby_grant got grant %b s %b exp grant 0100 s 10", grant, s);
    end
    i = 4'b0100;
    #1;
    checks++;
    if (y !== 1'b1) begin errors++; $display("FAIL comby_high got %b exp %b", y, 1'b1); end
    i = 4'b0000;
    #1;
    checks++;
    if (y !== 1'b0) begin errors++; $display("FAIL comby_low got %b exp %b", y, 1'b0); end
    i = 4'b1011;
    #1;
    checks++;
    if (y !== 1'b0) begin errors++; $display("FAIL comby_other_lanes got %b exp %b", y, 1'b0); end
    req = 4'b0000;
    i   = 4'b0100;
    tick();
    checks++;
    if (valid !== 1'b0 || s !== 2'b10 || y !== 1'b0) begin
      errors++;
      $display("FAIL comby_idle got valid %b s %b y %b exp valid 0 s 10 y 0", valid, s, y);
    end
    i = 4'b0000;
  endtask

`ifdef BURST_LIMIT_EN
  task automatic test_burst();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b0011;
    for (int r = 0; r < 4; r++) begin
      exp_g = (r % 2 == 0) ? 4'b0001 : 4'b0010;
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++;
        if (grant !== exp_g) begin
          errors++;
          $display("FAIL burst_alternate round %0d cycle %0d got %b exp %b", r, c, grant, exp_g);
        end
      end
    end
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0001) begin
        errors++;
        $display("FAIL burst_lone_hold cycle %0d got %b exp %b", c, grant, 4'b0001);
      end
    end
    req = 4'b0000;
    tick();
  endtask
`else
  task automatic test_no_burst();
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0001) begin
        errors++;
        $display("FAIL noburst_hold cycle %0d got %b exp %b", c, grant, 4'b0001);
      end
    end
    req = 4'b1111;
    tick();
    req = 4'b1001;
    tick();
    checks++;
    if (grant !== 4'b0001 || s !== 2'b00) begin
      errors++;
      $display("FAIL noburst_other_bits got grant %b s %b exp grant 0001 s 00", grant, s);
    end
    req = 4'b0000;
    tick();
  endtask
`endif

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL rstmid_pre got %b exp %b", grant, 4'b0100); end
    rst = 1'b1;
    req = 4'b1100;
    tick();
    checks++;
    if (grant !== 4'b0000 || valid !== 1'b0 || s !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_drop got grant %b valid %b s %b exp grant 0000 valid 0 s 00", grant, valid, s);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0100 || s !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_restart got grant %b s %b exp grant 0100 s 10", grant, s);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = 4'b0000;
    i   = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_comb_y();
`ifdef BURST_LIMIT_EN
    test_burst();
`else
    test_no_burst();
`endif
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive grant cycles per requester when burst limiting is compiled in (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: req  input  4  per-requester request, bit n = requester n.
REQ-005 Port: i  input  4  per-requester 1-bit data lane, bit n = requester n.
REQ-006 Port: grant  output  4  one-hot registered grant, all-zero when idle.
REQ-007 Port: s  output  2  registered select index of the granted requester.
REQ-008 Port: valid  output  1  registered, high while any grant is active.
REQ-009 Port: y  output  1  shared channel output, combinational: y = valid & i[s].

Function
REQ-010 Block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 IDLE: grant=0000, valid=0, s holds last value; if req!=0, next edge SHALL enter GRANT with the winner selected.
REQ-012 Winner SHALL be the first set bit of req searched circularly starting at index ptr (ptr, ptr+1, ... mod 4).
REQ-013 On entering GRANT with winner w: grant=one-hot(w), s=w, valid=1, ptr SHALL update to (w+1) mod 4.
REQ-014 GRANT, req[s]=1 and no forced release: grant, s and valid SHALL hold.
REQ-015 GRANT, req[s]=0: if any other req bit set, next edge SHALL grant the next winner per REQ-012 with no idle bubble; else next edge SHALL return to IDLE.
REQ-016 Request changes on non-granted bits SHALL have no effect until the next arbitration point.
REQ-017 grant SHALL never have more than one bit set; grant[s]=valid at all times.
REQ-018 Grant latency from req rising in IDLE to valid=1 SHALL be exactly 1 cycle.
REQ-019 y SHALL follow i[s] combinationally in the same cycle while valid=1, and SHALL be 0 while valid=0.

Reset
REQ-020 rst=1 SHALL force on next edge: state=IDLE, grant=0000, s=00, valid=0, ptr=0, burst counter=0.
REQ-021 rst SHALL dominate every other condition, including mid-grant; the active grant drops 1 cycle after rst is sampled.
REQ-022 After rst deasserts, first arbitration SHALL start search at requester 0.

Configuration
REQ-023 Macro BURST_LIMIT_EN SHALL compile in a burst counter (width ceil(log2(MAX_BURST))) cleared on each new grant and incremented each GRANT cycle.
REQ-024 With BURST_LIMIT_EN: when counter = MAX_BURST-1, req[s]=1 and any other req bit set, next edge SHALL force re-arbitration per REQ-012 (current requester excluded, ptr already past it).
REQ-025 With BURST_LIMIT_EN: when counter = MAX_BURST-1 and no other requester, grant SHALL hold and counter SHALL reset to 0.
REQ-026 Without BURST_LIMIT_EN: no counter exists; a grant SHALL persist until its req drops.

Verification
REQ-027 rst, then req=0001, i=0001 -> 1 cycle later grant=0001, s=00, valid=1, y=1; drop req -> next cycle valid=0, y=0.
REQ-028 From reset, req=1111 held, each requester dropping req after 2 grant cycles -> grant order 0001,0010,0100,1000,0001, no idle cycle between grants.
REQ-029 Requester 2 granted, i=0100 then i=0000 -> y=1 then y=0 in the same cycles (combinational path).
REQ-030 BURST_LIMIT_EN, MAX_BURST=4, req=0011 held -> requester 0 granted exactly 4 cycles, then requester 1 for 4, alternating; req=0001 alone -> grant held indefinitely.
REQ-031 Without BURST_LIMIT_EN, req=0011 held -> grant=0001 never changes.
REQ-032 rst asserted during grant=0100 -> next cycle grant=0000, valid=0; with req=1100 after release, first grant=0100 (search from 0).
